fifo_core: RTL and testbench
============================

Name: fifo_core

Overview:
- Synchronous single-clock FIFO that is the DUT end of the team's FIFO verification interface.
- It accepts writes and reads driven by the UVM driver.
- It returns status flags and read data sampled by the monitor.
- 128-bit data path; depth and almost-full/almost-empty levels are parameterised.

Parameters:
- DATA_W, 128, data width in bits.
- DEPTH, 16, number of entries; must be a power of 2 and at least 4.
- ALM_FULL_LVL, 14, o_alm_full asserts when occupancy >= this value.
- ALM_EMPTY_LVL, 2, o_alm_empty asserts when occupancy <= this value.

Ports:
- clk  input  1  clock; all logic on the rising edge.
- reset  input  1  synchronous, active-high reset.
- i_wren  input  1  write request.
- i_rden  input  1  read request.
- i_wrdata  input  DATA_W  write data.
- o_full  output  1  occupancy == DEPTH.
- o_empty  output  1  occupancy == 0.
- o_alm_full  output  1  occupancy >= ALM_FULL_LVL.
- o_alm_empty  output  1  occupancy <= ALM_EMPTY_LVL.
- o_rddata  output  DATA_W  registered read data.

Behaviour:
- Interface decisions: one clock, clk. Reset is synchronous and active-high, on port reset.
- Reset: on a rising edge with reset=1, clear state.
  - wr_ptr, rd_ptr and count go to 0.
  - o_rddata=0, o_empty=1, o_alm_empty=1, o_full=0, o_alm_full=0.
  - Storage contents are not cleared.
  - Reset mid-operation discards all entries; requests in that cycle are ignored.
- Internal widths: ADDR_W = $clog2(DEPTH); pointers are ADDR_W bits; count is ADDR_W+1 bits.
- Write acceptance: wr_acc = i_wren & ~o_full. On wr_acc, mem[wr_ptr] <= i_wrdata and wr_ptr increments, wrapping DEPTH-1 -> 0.
- Read acceptance: rd_acc = i_rden & ~o_empty. On rd_acc, o_rddata <= mem[rd_ptr] and rd_ptr increments, wrapping.
- Read latency: data is visible the cycle after i_rden is sampled high. o_rddata holds its value when no read is accepted.
- Count update: count_next = count + wr_acc - rd_acc.
- Simultaneous read and write, neither full nor empty: both accepted, count unchanged.
- Empty with both requests: write accepted, read ignored. There is no bypass; o_rddata is unchanged.
- Full with both requests: read accepted, write ignored and its data dropped.
- Write while full, or read while empty: silently ignored; no state change.
- Flags are registered from count_next, so they update on the same edge as the access causing them. There is no combinational path from inputs to outputs.
- Threshold arithmetic: compare unsigned at ADDR_W+1 bits. Elaboration error if ALM_EMPTY_LVL >= ALM_FULL_LVL or ALM_FULL_LVL > DEPTH.

Optional Feature:
- Macro: FIFO_ERR_FLAGS_EN.
- When defined, add two ports:
  - o_overflow (output, 1): sticky, set on i_wren & o_full.
  - o_underflow (output, 1): sticky, set on i_rden & o_empty.
  - Both clear only on reset. Each sets on the edge after the offending request, and the FIFO state is unaffected.
- When undefined: ports and logic are absent; illegal accesses are silently ignored as above.

Decomposition:
- Package fifo_pkg holds:
  - localparam FIFO_DATA_W = 128 and typedef logic [FIFO_DATA_W-1:0] fifo_data_t.
  - Default DEPTH and threshold constants.
  - fifo_pkg is shared with the testbench and scoreboard.
- One sub-module, fifo_mem: simple dual-port array.
  - Write port: we, waddr, wdata.
  - Read port: re, raddr, registered rdata, holding when re=0.
- fifo_core keeps the pointers, count, flags and the optional error logic.

Test Plan:
1. Reset then idle: reset=1 for 2 cycles, release. Required: o_empty=1, o_alm_empty=1, o_full=0, o_alm_full=0, o_rddata=0.
2. Fill to full: 16 writes of 0x1..0x10 with no reads.
   - o_alm_empty drops after the 3rd write.
   - o_empty drops after the 1st write.
   - o_alm_full rises after the 14th write; o_full rises after the 16th.
   - A 17th write of 0xDEAD is dropped.
3. Drain: 16 reads after scenario 2. Required: o_rddata = 0x1..0x10 in order, each one cycle after its i_rden. o_empty=1 after the 16th read. A 17th read leaves o_rddata=0x10.
4. Simultaneous read/write at occupancy 8, for 40 cycles: count stays 8, data stays in order, and pointers wrap at least twice.
5. Boundary and reset cases:
   - Empty FIFO with wren=rden=1 and data 0xAA: occupancy becomes 1, o_rddata unchanged.
   - Full FIFO with both requests: occupancy becomes 15, the head entry is read, write data is lost.
   - Reset asserted at occupancy 5: all flags return to reset values. The next write/read returns only the new data.
6. With FIFO_ERR_FLAGS_EN defined:
   - Write while full: o_overflow=1 one cycle later.
   - Read while empty: o_underflow=1.
   - Both flags stay set until reset.

Source files
------------

// File: rtl/fifo_pkg.sv
// Shared types and default sizing for fifo_core, used by the RTL and the testbench.
package fifo_pkg;

    localparam int FIFO_DATA_W        = 128;
    localparam int FIFO_DEPTH         = 16;
    localparam int FIFO_ALM_FULL_LVL  = 14;
    localparam int FIFO_ALM_EMPTY_LVL = 2;

    typedef logic [FIFO_DATA_W-1:0] fifo_data_t;

endpackage

// File: rtl/fifo_mem.sv
// Simple dual-port storage array for fifo_core: one write port and one registered read port.
// The array itself is never reset; only the read register clears.
module fifo_mem
    import fifo_pkg::*;
#(
    parameter int DATA_W = FIFO_DATA_W,
    parameter int DEPTH  = FIFO_DEPTH,
    parameter int ADDR_W = $clog2(FIFO_DEPTH)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic              re,
    input  logic [ADDR_W-1:0] raddr,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    // Read data holds its last value whenever no read is requested.
    always_ff @(posedge clk) begin
        if (reset) begin
            rdata <= '0;
        end else if (re) begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/fifo_core.sv
// Synchronous single-clock FIFO with registered status flags and registered read data.
// Define FIFO_ERR_FLAGS_EN to add sticky o_overflow / o_underflow outputs.
module fifo_core
    import fifo_pkg::*;
#(
    parameter int DATA_W        = FIFO_DATA_W,
    parameter int DEPTH         = FIFO_DEPTH,
    parameter int ALM_FULL_LVL  = FIFO_ALM_FULL_LVL,
    parameter int ALM_EMPTY_LVL = FIFO_ALM_EMPTY_LVL
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              i_wren,
    input  logic              i_rden,
    input  logic [DATA_W-1:0] i_wrdata,
    output logic              o_full,
    output logic              o_empty,
    output logic              o_alm_full,
    output logic              o_alm_empty,
    output logic [DATA_W-1:0] o_rddata
`ifdef FIFO_ERR_FLAGS_EN
    ,
    output logic              o_overflow,
    output logic              o_underflow
`endif
);

    localparam int ADDR_W = $clog2(DEPTH);
    localparam int CNT_W  = ADDR_W + 1;

    localparam logic [CNT_W-1:0] FULL_CNT  = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] AF_CNT    = CNT_W'(ALM_FULL_LVL);
    localparam logic [CNT_W-1:0] AE_CNT    = CNT_W'(ALM_EMPTY_LVL);

    if (DEPTH < 4 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
        $error("fifo_core: DEPTH must be a power of 2 and at least 4");
    end
    if (ALM_EMPTY_LVL >= ALM_FULL_LVL || ALM_FULL_LVL > DEPTH) begin : g_bad_levels
        $error("fifo_core: need ALM_EMPTY_LVL < ALM_FULL_LVL <= DEPTH");
    end

    logic [ADDR_W-1:0] wr_ptr;
    logic [ADDR_W-1:0] rd_ptr;
    logic [CNT_W-1:0]  count;
    logic [CNT_W-1:0]  count_next;
    logic              wr_acc;
    logic              rd_acc;

    // Acceptance uses the registered flags, so nothing combinational reaches the outputs.
    always_comb begin
        wr_acc     = i_wren & ~o_full;
        rd_acc     = i_rden & ~o_empty;
        count_next = count + CNT_W'(wr_acc) - CNT_W'(rd_acc);
    end

    fifo_mem #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_mem (
        .clk   (clk),
        .reset (reset),
        .we    (wr_acc & ~reset),
        .waddr (wr_ptr),
        .wdata (i_wrdata),
        .re    (rd_acc & ~reset),
        .raddr (rd_ptr),
        .rdata (o_rddata)
    );

    // Pointers wrap naturally because DEPTH is a power of 2.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            count       <= '0;
            o_full      <= 1'b0;
            o_empty     <= 1'b1;
            o_alm_full  <= 1'b0;
            o_alm_empty <= 1'b1;
        end else begin
            if (wr_acc) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (rd_acc) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            count       <= count_next;
            o_full      <= (count_next == FULL_CNT);
            o_empty     <= (count_next == '0);
            o_alm_full  <= (count_next >= AF_CNT);
            o_alm_empty <= (count_next <= AE_CNT);
        end
    end

`ifdef FIFO_ERR_FLAGS_EN
    // Sticky error flags record any illegal request until the next reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            o_overflow  <= 1'b0;
            o_underflow <= 1'b0;
        end else begin
            o_overflow  <= o_overflow  | (i_wren & o_full);
            o_underflow <= o_underflow | (i_rden & o_empty);
        end
    end
`endif

endmodule

// File: tb/tb_fifo_core.sv
// Scoreboard bench for fifo_core: directed scenarios plus random traffic against a queue model.
// Honours FIFO_ERR_FLAGS_EN when the design is built with it.
module tb_fifo_core;
    import fifo_pkg::*;

    localparam int DEPTH = FIFO_DEPTH;

    typedef struct {
        logic [3:0]  flags;
        fifo_data_t  rddata;
        logic [1:0]  err;
    } exp_t;

    logic       clk;
    logic       reset;
    logic       i_wren;
    logic       i_rden;
    fifo_data_t i_wrdata;
    logic       o_full;
    logic       o_empty;
    logic       o_alm_full;
    logic       o_alm_empty;
    fifo_data_t o_rddata;
    logic [1:0] err_act;

    int n_checks;
    int n_fail;

    fifo_data_t model_q[$];
    fifo_data_t model_rd;
    logic [1:0] model_err;
    exp_t       exp_q[$];
    exp_t       mon_e;

    fifo_core dut (
        .clk         (clk),
        .reset       (reset),
        .i_wren      (i_wren),
        .i_rden      (i_rden),
        .i_wrdata    (i_wrdata),
        .o_full      (o_full),
        .o_empty     (o_empty),
        .o_alm_full  (o_alm_full),
        .o_alm_empty (o_alm_empty),
        .o_rddata    (o_rddata)
`ifdef FIFO_ERR_FLAGS_EN
        ,
        .o_overflow  (err_act[1]),
        .o_underflow (err_act[0])
`endif
    );

`ifndef FIFO_ERR_FLAGS_EN
    assign err_act = 2'b00;
`endif

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_output(input string name, input fifo_data_t act, input fifo_data_t req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("[TB] FAIL %s: got %h, expected %h", name, act, req);
        end
    endtask

    // Drive one cycle of requests and record what the FIFO must look like after the edge.
    task automatic apply_stimulus(input bit rst, input bit wr, input bit rd, input fifo_data_t d);
        exp_t e;
        bit   was_full;
        bit   was_empty;
        int   occ;
        @(negedge clk);
        reset    = rst;
        i_wren   = wr;
        i_rden   = rd;
        i_wrdata = d;
        if (rst) begin
            model_q.delete();
            model_rd  = '0;
            model_err = 2'b00;
        end else begin
            was_full  = (model_q.size() == DEPTH);
            was_empty = (model_q.size() == 0);
            if (wr && was_full) model_err[1] = 1'b1;
            if (rd && was_empty) model_err[0] = 1'b1;
            if (rd && !was_empty) model_rd = model_q.pop_front();
            if (wr && !was_full) model_q.push_back(d);
        end
        occ = model_q.size();
        e.flags  = {occ == DEPTH, occ == 0, occ >= FIFO_ALM_FULL_LVL, occ <= FIFO_ALM_EMPTY_LVL};
        e.rddata = model_rd;
`ifdef FIFO_ERR_FLAGS_EN
        e.err = model_err;
`else
        e.err = 2'b00;
`endif
        exp_q.push_back(e);
    endtask

    function automatic fifo_data_t rand_data();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // Monitor: one expected record per clocked cycle, sampled just after the edge.
    always @(posedge clk) begin
        #1;
        if (exp_q.size() > 0) begin
            mon_e = exp_q.pop_front();
            check_output("flags{full,empty,afull,aempty}",
                         fifo_data_t'({o_full, o_empty, o_alm_full, o_alm_empty}),
                         fifo_data_t'(mon_e.flags));
            check_output("rddata", o_rddata, mon_e.rddata);
`ifdef FIFO_ERR_FLAGS_EN
            check_output("err{overflow,underflow}", fifo_data_t'(err_act), fifo_data_t'(mon_e.err));
`endif
        end
    end

    initial begin
        int wait_cycles;
        n_checks  = 0;
        n_fail    = 0;
        model_rd  = '0;
        model_err = 2'b00;
        reset     = 1'b1;
        i_wren    = 1'b0;
        i_rden    = 1'b0;
        i_wrdata  = '0;

        // Reset then idle.
        apply_stimulus(1, 0, 0, '0);
        apply_stimulus(1, 0, 0, '0);
        apply_stimulus(0, 0, 0, '0);

        // Fill to full, then one dropped write.
        for (int i = 1; i <= DEPTH; i++) apply_stimulus(0, 1, 0, fifo_data_t'(i));
        apply_stimulus(0, 1, 0, fifo_data_t'(32'hDEAD));

        // Drain, then one read on empty.
        for (int i = 0; i <= DEPTH; i++) apply_stimulus(0, 0, 1, '0);

        // Simultaneous traffic at occupancy 8 long enough to wrap the pointers.
        for (int i = 0; i < 8; i++) apply_stimulus(0, 1, 0, rand_data());
        for (int i = 0; i < 40; i++) apply_stimulus(0, 1, 1, rand_data());

        // Empty with both requests: write only.
        apply_stimulus(1, 0, 0, '0);
        apply_stimulus(0, 1, 1, fifo_data_t'(8'hAA));
        apply_stimulus(0, 0, 1, '0);

        // Full with both requests: read only.
        for (int i = 0; i < DEPTH; i++) apply_stimulus(0, 1, 0, rand_data());
        apply_stimulus(0, 1, 1, rand_data());
        apply_stimulus(0, 0, 1, '0);

        // Reset mid-operation at occupancy 5.
        apply_stimulus(1, 0, 0, '0);
        for (int i = 0; i < 5; i++) apply_stimulus(0, 1, 0, rand_data());
        apply_stimulus(1, 1, 1, rand_data());
        apply_stimulus(0, 1, 0, fifo_data_t'(32'h1234_5678));
        apply_stimulus(0, 0, 1, '0);
        apply_stimulus(0, 0, 1, '0);

        // Random traffic with occasional resets.
        for (int i = 0; i < 400; i++) begin
            apply_stimulus($urandom_range(0, 59) == 0,
                           $urandom_range(0, 99) < 55,
                           $urandom_range(0, 99) < 45,
                           rand_data());
        end
        apply_stimulus(0, 0, 0, '0);

        wait_cycles = 0;
        while (exp_q.size() > 0 && wait_cycles < 20) begin
            @(posedge clk);
            wait_cycles++;
        end
        #2;
        if (exp_q.size() > 0) begin
            n_checks++;
            n_fail++;
            $display("[TB] FAIL drain_scoreboard: %0d records left, expected 0", exp_q.size());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
